// File: rtl/mem_arbiter_pkg.sv
// Global: shared types for the memory arbiter slice
package Global;
  typedef logic [31:0] size_t;
  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, RESP = 2'd2} arb_state_e;
endpackage

// File: rtl/mem_arbiter_rr_pick.sv
// mem_arb_rr_pick: lowest active index at or above the pointer wins, with wraparound
module mem_arb_rr_pick #(
  parameter int NREQ = 2
) (
  input  logic [NREQ-1:0]         req_vec,
  input  logic [$clog2(NREQ)-1:0] rr_ptr,
  output logic                    valid,
  output logic [$clog2(NREQ)-1:0] idx
);
  localparam int IW = $clog2(NREQ);
  // scan from farthest to nearest so the nearest active requester overwrites
  always_comb begin
    valid = |req_vec;
    idx = '0;
    for (int k = NREQ - 1; k >= 0; k--)
      if (req_vec[IW'((int'(rr_ptr) + k) % NREQ)]) idx = IW'((int'(rr_ptr) + k) % NREQ);
  end
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin share of one memory port among NREQ requesters
module mem_arbiter
  import Global::*;
#(
  parameter int NREQ    = 2,
  parameter int TIMEOUT = 255
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NREQ-1:0]         req_read,
  input  logic [NREQ-1:0]         req_write,
  input  logic [3:0]              req_byte_enable [NREQ],
  input  size_t                   req_address [NREQ],
  input  size_t                   req_wdata [NREQ],
  output logic [NREQ-1:0]         req_resp,
  output logic [31:0]             req_rdata,
  output logic                    req_err,
  output logic                    mem_read,
  output logic                    mem_write,
  output logic [3:0]              mem_byte_enable,
  output size_t                   mem_address,
  output size_t                   mem_wdata,
  input  logic                    mem_resp,
  input  logic [31:0]             mem_rdata,
  output logic [$clog2(NREQ)-1:0] grant_id
);
  localparam int IW = $clog2(NREQ);
  localparam int CW = $clog2(TIMEOUT + 2);
  arb_state_e      r_state;
  logic [IW-1:0]   r_ptr;
  logic [IW-1:0]   r_grant;
  logic            r_rd;
  logic            r_wr;
  logic [3:0]      r_be;
  size_t           r_addr;
  size_t           r_wdata;
  logic [CW-1:0]   r_cnt;
  logic [31:0]     r_rdata;
  logic            r_err;
  logic            w_valid;
  logic [IW-1:0]   w_idx;
  logic            w_timeout;
  logic [IW-1:0]   w_next_ptr;
  mem_arb_rr_pick #(.NREQ(NREQ)) u_pick (
    .req_vec (req_read | req_write),
    .rr_ptr  (r_ptr),
    .valid   (w_valid),
    .idx     (w_idx)
  );
  assign w_timeout       = (TIMEOUT != 0) && (r_cnt == CW'(TIMEOUT));
  assign w_next_ptr      = (r_grant == IW'(NREQ - 1)) ? '0 : r_grant + 1'b1;
  assign mem_read        = (r_state == BUSY) & r_rd;
  assign mem_write       = (r_state == BUSY) & r_wr;
  assign mem_byte_enable = r_be;
  assign mem_address     = r_addr;
  assign mem_wdata       = r_wdata;
  assign req_rdata       = r_rdata;
  assign req_err         = r_err;
  assign grant_id        = r_grant;
  assign req_resp        = (r_state == RESP) ? ({{(NREQ-1){1'b0}}, 1'b1} << r_grant) : '0;
  // arbitration, transaction hold, watchdog and result capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_ptr   <= '0;
      r_grant <= '0;
      r_rd    <= 1'b0;
      r_wr    <= 1'b0;
      r_be    <= '0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_cnt   <= '0;
      r_rdata <= '0;
      r_err   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (w_valid) begin
          r_grant <= w_idx;
          r_wr    <= req_write[w_idx];
          r_rd    <= req_read[w_idx] & ~req_write[w_idx];
          r_be    <= req_byte_enable[w_idx];
          r_addr  <= req_address[w_idx];
          r_wdata <= req_wdata[w_idx];
          r_cnt   <= CW'(1);
          r_state <= BUSY;
        end
        BUSY: if (mem_resp) begin
          r_rdata <= mem_rdata;
          r_err   <= 1'b0;
          r_state <= RESP;
        end else if (w_timeout) begin
          r_rdata <= '0;
          r_err   <= 1'b1;
          r_state <= RESP;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
        RESP: begin
          r_ptr   <= w_next_ptr;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Shares the single `memory` port among `NREQ` CPU-side requesters, for example instruction fetch and load/store. It round-robins between requesters and latches the winning request. It drives the memory handshake until `resp` arrives or a watchdog expires, then returns registered read data and a one-cycle `resp` pulse to the winning requester. It sits between the `cpu` mem-port ports and `memory` in `top`. Both sides use the same read/write/resp protocol.

## Interface
Parameters:
- `NREQ`, default 2: number of requesters, 2..8.
- `TIMEOUT`, default 255: maximum number of BUSY cycles to wait for `mem_resp`; 0 disables the watchdog.

Ports:
- `clk`  in  1: the only clock; all state updates on its rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `req_read[NREQ]`  in  1 each: read request; held high until that requester's `req_resp`.
- `req_write[NREQ]`  in  1 each: write request; same hold rule.
- `req_byte_enable[NREQ]`  in  4 each: byte lanes for a write.
- `req_address[NREQ]`  in  `Global::size_t` each.
- `req_wdata[NREQ]`  in  `Global::size_t` each.
- `req_resp[NREQ]`  out  1 each: one-cycle completion pulse.
- `req_rdata`  out  32: read data; shared by all requesters, valid while any `req_resp` is high.
- `req_err`  out  1: high together with `req_resp` when the transaction timed out.
- `mem_read`, `mem_write`  out  1 each: memory-side request strobes.
- `mem_byte_enable`  out  4.
- `mem_address`, `mem_wdata`  out  `Global::size_t` each.
- `mem_resp`  in  1: memory completion strobe.
- `mem_rdata`  in  32: memory read data.
- `grant_id`  out  `$clog2(NREQ)`: index of the requester currently or last granted.

## Operation
States: IDLE, BUSY and RESP.

IDLE:
- The arbiter picks the first active requester, searching from `rr_ptr` upward with wrap-around.
- A requester is active when `req_read|req_write` is high for it.
- On a pick, the arbiter latches the winner's op, address, wdata, byte_enable and index, then moves to BUSY.
- If no requester is active, it stays in IDLE.

BUSY:
- `mem_read`/`mem_write` and the address, wdata and byte_enable outputs are driven from the latched registers and held stable.
- A watchdog counter increments each cycle.
- On `mem_resp`: `mem_rdata` is captured into `req_rdata`, `req_err` is set to 0, and the state moves to RESP.
- If `TIMEOUT`≠0 and the counter reaches `TIMEOUT` with no `mem_resp`: `req_rdata` is set to 0, `req_err` is set to 1, and the state moves to RESP.

RESP:
- `req_resp[grant_id]` is high for exactly one cycle.
- `mem_read` and `mem_write` are 0.
- `rr_ptr` is set to `(grant_id+1) mod NREQ`.
- The next state is IDLE.

Rules:
- Read and write high together from one requester is illegal. The arbiter performs the write only: `mem_write=1`, `mem_read=0`.
- Requests and operand changes from any requester are ignored outside IDLE.
- `mem_resp` is ignored in IDLE and RESP.
- The memory must not respond to an aborted (timed-out) transaction after its strobe drops.
- `req_rdata` and `req_err` hold their value until the next capture.
- Reset (async, at any time including mid-BUSY) forces:
  - state IDLE, `rr_ptr`=0, `grant_id`=0, counter 0;
  - all strobes, `req_resp`, `req_err`, `req_rdata` and memory-side data/address outputs to 0.
- An in-flight transaction is dropped without a `req_resp`.

## Timing
- Request seen in IDLE at cycle t: memory strobe high at t+1.
- `mem_resp` at cycle u ≥ t+1: `req_resp` and `req_rdata` at u+1; strobe low at u+1.
- Minimum round trip is 2 cycles.
- The next arbitration happens at u+2, so the minimum issue interval is 3 cycles.
- Watchdog: counter = 1 in the first BUSY cycle; timeout when the counter equals `TIMEOUT`, so `req_resp`+`req_err` arrive at t+`TIMEOUT`+1.
- A requester sees `req_resp` in cycle r. It must drop its request or present a new one at r+1, when the arbiter is already in IDLE.

## Structure
- Add `arb_state_e` (IDLE/BUSY/RESP) to package `Global`; reuse `Global::size_t`.
- One sub-module, `mem_arb_rr_pick`:
  - combinational;
  - inputs: request vector and `rr_ptr`;
  - outputs: `valid` and winner index;
  - lowest index at or above the pointer wins, with wraparound.

## Test plan
- Single read: only req0 reads 0x100 and memory responds 1 cycle after the strobe with 0xDEADBEEF. Expect `mem_read` at t+1 and `req_resp[0]`=1 at t+3 with `req_rdata`=0xDEADBEEF and `req_err`=0.
- Contention: req0 and req1 both request continuously after reset. Expect grants ordered 0,1,0,1, with each `req_resp` pulse one cycle wide.
- Write with byte lanes: req1 writes 0x12345678 to 0x40 with `byte_enable`=4'b0011. Expect the memory side to see exactly those values held stable across 5 wait cycles.
- Timeout: `TIMEOUT`=4 and memory never responds. Expect `req_resp`=1 and `req_err`=1 at t+5, `req_rdata`=0, and the strobe dropped.
- Reset mid-BUSY: assert `rst_n`=0 during a pending read. Expect all outputs 0 immediately and no `req_resp`. After release, req1 alone is granted first with `grant_id`=1.
- Illegal read+write from req0: expect `mem_write`=1 and `mem_read`=0.
